branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage branch target buffer with 2-bit saturating direction counters.
- Fetch side: looks up F_PC every cycle and produces the prediction triple. That triple is carried down the pipe and arrives at the hazard unit as E_prediction_made, E_predicted_taken and E_btb_PCtarget.
- Execute side: is trained from resolved branch/jump outcomes.
- Also keeps lookup-hit and mispredict statistics counters for performance runs.

Parameters:
- ENTRIES, 16, number of direct-mapped BTB entries; power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), index width. Derived; do not override.
- TAG_W, 30-IDX_W, tag width. Derived; do not override.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- F_PC  in  32  fetch-stage PC.
- F_prediction_made  out  1  F_PC hit a valid entry.
- F_predicted_taken  out  1  a hit and counter MSB=1, or the entry is a JAL.
- F_btb_PCtarget  out  32  stored target of the hit entry; 0 on a miss.
- E_opcode  in  7  opcode of the instruction in execute.
- E_PC  in  32  PC of the instruction in execute.
- E_update_en  in  1  the execute instruction is valid and not squashed. It is D_E_en gated with not-bubble.
- E_branch_taken  in  1  resolved direction. Ignored for JAL.
- E_PCTarget  in  32  resolved target.
- E_mispredict  in  1  branch_mispredict, as computed by the hazard unit.
- clear_table  in  1  synchronous invalidate of all entries.
- stat_hits  out  CNT_W  number of lookup hits.
- stat_mispredicts  out  CNT_W  number of mispredicts.

Behaviour:
- Address split:
  - index = PC[IDX_W+1:2]
  - tag = PC[31:IDX_W+2]
  - PC[1:0] is ignored.
- Lookup is purely combinational and has zero latency.
  - Hit = valid[index] && tag matches.
  - On a miss all three F_ outputs are 0.
- Trained instruction classes:
  - Branch, opcode 1100011.
  - JAL, opcode 1101111.
  - JALR (1100111) and all other opcodes are never allocated or trained.
- Training happens at the rising clock edge when E_update_en=1 and the class is Branch or JAL. Let E-hit be a hit on E_PC.
  - Branch, E-hit, taken: counter increments, saturating at 11; target <= E_PCTarget.
  - Branch, E-hit, not taken: counter decrements, saturating at 00; target is unchanged.
  - Branch, miss, taken: allocate (overwrite) the entry with valid=1, tag, target, counter=10, is_jal=0.
  - Branch, miss, not taken: no write.
  - JAL, hit or miss: write valid=1, tag, target, counter=11, is_jal=1.
- Read/write ordering: a same-cycle lookup and update of the same index returns the pre-update entry. There is no bypass.
- clear_table=1 clears every valid bit at the next edge and has priority over a same-cycle update.
- Statistics:
  - stat_hits increments when F_prediction_made=1.
  - stat_mispredicts increments when E_update_en && E_mispredict.
  - Both wrap modulo 2^CNT_W and are not affected by clear_table.
- Reset (rst_n=0, asynchronous):
  - All valid bits clear, all counters go to 01, all statistics go to 0.
  - Targets and tags are don't-care.
  - While in reset the F_ outputs read 0, since every lookup misses.
  - On release, the first edge may train.
- Reset asserted mid-update: the write is lost. No partial entry may become visible.

Decomposition:
- Shared package bp_pkg holds:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - Counter enum bp_cnt_t: strong_nt=2'b00, weak_nt=2'b01, weak_t=2'b10, strong_t=2'b11.
  - Entry struct btb_entry_t {valid, is_jal, tag, target, cnt}.
- One sub-module sat_counter2, a combinational next-state for the 2-bit counter with inputs inc and dec. It is instantiated per update path, not per entry.

Test Plan:
- Reset, then F_PC=0x100 -> F_prediction_made=0, F_btb_PCtarget=0, both statistics 0.
- Branch at E_PC=0x100, taken, target 0x80; then F_PC=0x100 -> made=1, taken=1 (counter 10), target=0x80, stat_hits=1.
- Same branch not taken twice -> counter 10->01->00, predicted_taken=0. One more not-taken -> counter stays 00. Three taken -> counter 11; a fourth stays 11.
- JAL at 0x200 to 0x400; then a not-taken Branch update at 0x200 -> entry is rewritten as a branch only if the branch is taken. Lookup shows is_jal prediction taken=1, target 0x400.
- ENTRIES=16: taken branch at 0x100 then taken branch at 0x140 (same index 0, different tag) -> lookup at 0x100 misses and lookup at 0x140 hits. clear_table plus a same-cycle update -> all entries invalid.
- JALR (opcode 1100111) update with E_mispredict=1 -> no allocation, stat_mispredicts increments. Async reset mid-run -> statistics are 0 immediately and all lookups miss.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   OP_*        : RV32 major opcodes that the predictor distinguishes
//   bp_cnt_t    : 2-bit saturating direction counter states
//   btb_entry_t : one BTB entry. The tag field is sized for the smallest
//                 legal table (2 entries -> 30-1 bits would still fit in 30),
//                 and narrower tags are stored zero-extended.
package bp_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int MAX_TAG_W = 30;

    typedef enum logic [1:0] {
        strong_nt = 2'b00,
        weak_nt   = 2'b01,
        weak_t    = 2'b10,
        strong_t  = 2'b11
    } bp_cnt_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_jal;
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          target;
        bp_cnt_t              cnt;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter.
//   cnt      in  current counter state
//   inc      in  step towards strong_t (saturates)
//   dec      in  step towards strong_nt (saturates)
//   cnt_next out next counter state; inc and dec together hold the value
module sat_counter2
    import bp_pkg::*;
(
    input  bp_cnt_t cnt,
    input  logic    inc,
    input  logic    dec,
    output bp_cnt_t cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (inc && !dec) begin
            case (cnt)
                strong_nt: cnt_next = weak_nt;
                weak_nt:   cnt_next = weak_t;
                weak_t:    cnt_next = strong_t;
                default:   cnt_next = strong_t;
            endcase
        end else if (dec && !inc) begin
            case (cnt)
                strong_t:  cnt_next = weak_t;
                weak_t:    cnt_next = weak_nt;
                weak_nt:   cnt_next = strong_nt;
                default:   cnt_next = strong_nt;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch side looks up F_PC combinationally every cycle; execute side trains
// the table from resolved Branch and JAL outcomes. Also counts lookup hits
// and mispredicts.
//   clk, rst_n           clock, asynchronous active-low reset
//   F_PC                 fetch PC to look up
//   F_prediction_made    F_PC hit a valid entry
//   F_predicted_taken    hit and (counter says taken or entry is a JAL)
//   F_btb_PCtarget       stored target on a hit, 0 on a miss
//   E_opcode, E_PC       opcode / PC of the execute-stage instruction
//   E_update_en          execute instruction valid and not squashed
//   E_branch_taken       resolved direction (ignored for JAL)
//   E_PCTarget           resolved target
//   E_mispredict         hazard-unit mispredict flag
//   clear_table          invalidate all entries at the next edge
//   stat_hits            lookup-hit count (wraps)
//   stat_mispredicts     mispredict count (wraps)
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      F_PC,
    output logic             F_prediction_made,
    output logic             F_predicted_taken,
    output logic [31:0]      F_btb_PCtarget,
    input  logic [6:0]       E_opcode,
    input  logic [31:0]      E_PC,
    input  logic             E_update_en,
    input  logic             E_branch_taken,
    input  logic [31:0]      E_PCTarget,
    input  logic             E_mispredict,
    input  logic             clear_table,
    output logic [CNT_W-1:0] stat_hits,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int PAD_W = MAX_TAG_W - TAG_W;

    btb_entry_t              table_reg [ENTRIES];
    btb_entry_t              f_entry;
    btb_entry_t              e_entry;
    btb_entry_t              wr_entry;
    logic [IDX_W-1:0]        f_idx;
    logic [IDX_W-1:0]        e_idx;
    logic [MAX_TAG_W-1:0]    f_tag;
    logic [MAX_TAG_W-1:0]    e_tag;
    logic                    f_hit;
    logic                    e_hit;
    logic                    is_branch;
    logic                    is_jal_op;
    logic                    wr_en;
    bp_cnt_t                 cnt_next;
    logic [CNT_W-1:0]        hits_reg;
    logic [CNT_W-1:0]        mispredicts_reg;
    logic                    unused_pc_bits;

    // Byte-offset bits never take part in indexing or tagging.
    assign unused_pc_bits = ^{F_PC[1:0], E_PC[1:0]};

    assign f_idx = F_PC[IDX_W+1:2];
    assign e_idx = E_PC[IDX_W+1:2];
    assign f_tag = {{PAD_W{1'b0}}, F_PC[31:IDX_W+2]};
    assign e_tag = {{PAD_W{1'b0}}, E_PC[31:IDX_W+2]};

    // Both ports read the registered table, so a same-cycle lookup of an
    // entry being trained sees the old contents.
    assign f_entry = table_reg[f_idx];
    assign e_entry = table_reg[e_idx];
    assign f_hit   = f_entry.valid && (f_entry.tag == f_tag);
    assign e_hit   = e_entry.valid && (e_entry.tag == e_tag);

    assign F_prediction_made = f_hit;
    assign F_predicted_taken = f_hit && (f_entry.is_jal ||
                               f_entry.cnt == weak_t || f_entry.cnt == strong_t);
    assign F_btb_PCtarget    = f_hit ? f_entry.target : 32'd0;

    assign is_branch = (E_opcode == OP_BRANCH);
    assign is_jal_op = (E_opcode == OP_JAL);

    sat_counter2 u_sat_counter2 (
        .cnt      (e_entry.cnt),
        .inc      (is_branch && E_branch_taken),
        .dec      (is_branch && !E_branch_taken),
        .cnt_next (cnt_next)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = e_entry;
        if (E_update_en) begin
            if (is_jal_op) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, is_jal: 1'b1, tag: e_tag,
                             target: E_PCTarget, cnt: strong_t};
            end else if (is_branch) begin
                if (e_hit) begin
                    wr_en        = 1'b1;
                    wr_entry.cnt = cnt_next;
                    // A taken branch that lands on a JAL entry turns it into a
                    // branch entry; a not-taken one leaves the JAL flag alone.
                    if (E_branch_taken) begin
                        wr_entry.target = E_PCTarget;
                        wr_entry.is_jal = 1'b0;
                    end
                end else if (E_branch_taken) begin
                    wr_en    = 1'b1;
                    wr_entry = '{valid: 1'b1, is_jal: 1'b0, tag: e_tag,
                                 target: E_PCTarget, cnt: weak_t};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_reg[i] <= '{valid: 1'b0, is_jal: 1'b0, tag: '0,
                                  target: '0, cnt: weak_nt};
            end
        end else if (clear_table) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_reg[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            table_reg[e_idx] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_reg        <= '0;
            mispredicts_reg <= '0;
        end else begin
            if (f_hit) begin
                hits_reg <= hits_reg + 1'b1;
            end
            if (E_update_en && E_mispredict) begin
                mispredicts_reg <= mispredicts_reg + 1'b1;
            end
        end
    end

    assign stat_hits        = hits_reg;
    assign stat_mispredicts = mispredicts_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all checked against a small behavioural BTB model.
module tb_branch_predictor;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    localparam logic [6:0] OPB  = 7'b1100011;
    localparam logic [6:0] OPJ  = 7'b1101111;
    localparam logic [6:0] OPR  = 7'b1100111;
    localparam logic [6:0] OPX  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] F_PC;
    logic        F_prediction_made;
    logic        F_predicted_taken;
    logic [31:0] F_btb_PCtarget;
    logic [6:0]  E_opcode;
    logic [31:0] E_PC;
    logic        E_update_en;
    logic        E_branch_taken;
    logic [31:0] E_PCTarget;
    logic        E_mispredict;
    logic        clear_table;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;

    branch_predictor #(.ENTRIES(N), .CNT_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .F_PC              (F_PC),
        .F_prediction_made (F_prediction_made),
        .F_predicted_taken (F_predicted_taken),
        .F_btb_PCtarget    (F_btb_PCtarget),
        .E_opcode          (E_opcode),
        .E_PC              (E_PC),
        .E_update_en       (E_update_en),
        .E_branch_taken    (E_branch_taken),
        .E_PCTarget        (E_PCTarget),
        .E_mispredict      (E_mispredict),
        .clear_table       (clear_table),
        .stat_hits         (stat_hits),
        .stat_mispredicts  (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Behavioural model: per-slot valid/tag/target, a 0..3 strength value
    // and a jump flag; statistics as plain integers.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int unsigned m_tgt   [N];
    int          m_ctr   [N];
    bit          m_jal   [N];
    int unsigned m_hits;
    int unsigned m_mis;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (2 + IW);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
            m_jal[i]   = 0;
        end
        m_hits = 0;
        m_mis  = 0;
    endtask

    task automatic model_edge();
        int  s;
        bit  hit_e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_hit(F_PC)) m_hits++;
        if (E_update_en && E_mispredict) m_mis++;
        if (clear_table) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            return;
        end
        if (!E_update_en) return;
        s     = slot_of(E_PC);
        hit_e = m_hit(E_PC);
        if (E_opcode == OPJ) begin
            m_valid[s] = 1; m_tag[s] = tag_of(E_PC); m_tgt[s] = E_PCTarget;
            m_ctr[s] = 3; m_jal[s] = 1;
        end else if (E_opcode == OPB) begin
            if (hit_e && E_branch_taken) begin
                m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                m_tgt[s] = E_PCTarget;
                m_jal[s] = 0;
            end else if (hit_e) begin
                m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
            end else if (E_branch_taken) begin
                m_valid[s] = 1; m_tag[s] = tag_of(E_PC); m_tgt[s] = E_PCTarget;
                m_ctr[s] = 2; m_jal[s] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        bit h;
        int s;
        h = m_hit(F_PC);
        s = slot_of(F_PC);
        check("made",   {31'd0, F_prediction_made}, {31'd0, h});
        check("taken",  {31'd0, F_predicted_taken},
              {31'd0, h && (m_jal[s] || m_ctr[s] >= 2)});
        check("target", F_btb_PCtarget, h ? m_tgt[s] : 32'd0);
        check("hits",   stat_hits, m_hits);
        check("mispr",  stat_mispredicts, m_mis);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic upd(input logic [6:0] op, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic mis);
        E_update_en    = 1'b1;
        E_opcode       = op;
        E_PC           = pc;
        E_branch_taken = tk;
        E_PCTarget     = tgt;
        E_mispredict   = mis;
    endtask

    task automatic idle();
        E_update_en  = 1'b0;
        E_mispredict = 1'b0;
        clear_table  = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] tag_pool [3];
        tag_pool[0] = 32'h0000_0000;
        tag_pool[1] = 32'h0000_0040;
        tag_pool[2] = 32'hFFFF_FFC0;

        rst_n = 1'b0; F_PC = 32'h100; clear_table = 1'b0;
        E_opcode = OPX; E_PC = 0; E_branch_taken = 0; E_PCTarget = 0;
        E_update_en = 0; E_mispredict = 0;
        model_reset();
        @(negedge clk);
        cycle();
        check("rst_made", {31'd0, F_prediction_made}, 32'd0);
        check("rst_tgt", F_btb_PCtarget, 32'd0);
        check("rst_hits", stat_hits, 32'd0);
        rst_n = 1'b1;

        // Allocate a taken branch, then look it up.
        upd(OPB, 32'h100, 1, 32'h80, 0); cycle();
        idle(); cycle();
        check("alloc_tgt", F_btb_PCtarget, 32'h80);
        check("alloc_taken", {31'd0, F_predicted_taken}, 32'd1);
        check("alloc_hits", stat_hits, 32'd1);

        // Counter walk: 10 -> 01 -> 00 -> 00, then 01,10,11,11.
        for (int i = 0; i < 3; i++) begin upd(OPB, 32'h100, 0, 32'h0, 0); cycle(); end
        idle(); cycle();
        check("sat_low_taken", {31'd0, F_predicted_taken}, 32'd0);
        for (int i = 0; i < 4; i++) begin upd(OPB, 32'h100, 1, 32'h80, 0); cycle(); end
        idle(); cycle();

        // JAL then a not-taken branch at the same PC.
        F_PC = 32'h200;
        upd(OPJ, 32'h200, 0, 32'h400, 0); cycle();
        upd(OPB, 32'h200, 0, 32'h0, 0); cycle();
        idle(); cycle();
        check("jal_taken", {31'd0, F_predicted_taken}, 32'd1);
        check("jal_tgt", F_btb_PCtarget, 32'h400);

        // Same index, different tag.
        upd(OPB, 32'h140, 1, 32'h999C, 0); F_PC = 32'h100; cycle();
        idle(); cycle();
        check("alias_miss", {31'd0, F_prediction_made}, 32'd0);
        F_PC = 32'h140; cycle();
        check("alias_hit", {31'd0, F_prediction_made}, 32'd1);

        // Clear wins over a same-cycle update.
        clear_table = 1'b1; upd(OPJ, 32'h240, 0, 32'h10, 0); cycle();
        idle(); F_PC = 32'h240; cycle();
        check("clr_miss", {31'd0, F_prediction_made}, 32'd0);
        F_PC = 32'h140; cycle();

        // JALR never allocates but still counts a mispredict.
        upd(OPR, 32'h300, 1, 32'h500, 1); F_PC = 32'h300; cycle();
        idle(); cycle();
        check("jalr_miss", {31'd0, F_prediction_made}, 32'd0);
        check("jalr_mis", stat_mispredicts, 32'd1);

        // Randomized traffic over a small PC pool so entries collide and hit.
        for (int n = 0; n < 400; n++) begin
            pc = tag_pool[$urandom_range(0, 2)] | ($urandom_range(0, 15) << 2)
                 | $urandom_range(0, 3);
            F_PC = tag_pool[$urandom_range(0, 2)] | ($urandom_range(0, 15) << 2);
            case ($urandom_range(0, 3))
                0: E_opcode = OPB;
                1: E_opcode = OPJ;
                2: E_opcode = OPR;
                default: E_opcode = OPX;
            endcase
            if ($urandom_range(0, 3) == 0) E_opcode = OPB;
            E_PC           = pc;
            E_update_en    = ($urandom_range(0, 3) != 0);
            E_branch_taken = $urandom_range(0, 1) == 1;
            E_PCTarget     = $urandom;
            E_mispredict   = $urandom_range(0, 1) == 1;
            clear_table    = ($urandom_range(0, 39) == 0);
            cycle();
        end
        idle();

        // Asynchronous reset in the middle of an update.
        upd(OPB, 32'h7C, 1, 32'h1234, 1); F_PC = 32'h7C;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_hits", stat_hits, 32'd0);
        check("arst_mis", stat_mispredicts, 32'd0);
        check("arst_made", {31'd0, F_prediction_made}, 32'd0);
        @(negedge clk);
        cycle();
        idle();
        rst_n = 1'b1;
        cycle();
        check("post_rst_made", {31'd0, F_prediction_made}, 32'd0);
        for (int i = 0; i < N; i++) begin
            F_PC = 32'(i) << 2;
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
